// File: rtl/minirisc_ctrl_pkg.sv
// Shared types and constants for the KGP-miniRISC control sequencer.
package minirisc_ctrl_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FLAGS_W = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_ALU_R = 6'h00;
  localparam logic [OP_W-1:0] OP_ALU_I = 6'h01;
  localparam logic [OP_W-1:0] OP_LD    = 6'h02;
  localparam logic [OP_W-1:0] OP_ST    = 6'h03;
  localparam logic [OP_W-1:0] OP_BR    = 6'h04;
  localparam logic [OP_W-1:0] OP_BZ    = 6'h05;
  localparam logic [OP_W-1:0] OP_BNZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BMI   = 6'h07;
  localparam logic [OP_W-1:0] OP_BPL   = 6'h08;
  localparam logic [OP_W-1:0] OP_BCY   = 6'h09;
  localparam logic [OP_W-1:0] OP_CALL  = 6'h0A;
  localparam logic [OP_W-1:0] OP_JR    = 6'h0B;
  localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 3'd3;

  localparam logic [SEL_W-1:0] SEL_DATA2 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_ZERO  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_ADDR  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_ONE   = 2'd3;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_SIGN  = 1;
  localparam int unsigned FLAG_CARRY = 2;

  // Datapath control word driven toward the register file, memory and ALU.
  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               data_pc_sel;
    logic               reg_select;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   alu_in_sel;
  } ctrl_t;

  function automatic logic op_defined(input logic [OP_W-1:0] op);
    return (op <= OP_JR) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/minirisc_branch_resolve.sv
// Branch condition evaluation from the latched opcode and ALU flags.
module minirisc_branch_resolve
  import minirisc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op_q,
  input  logic [FLAGS_W-1:0] flags_q,
  output logic               taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (op_q)
      OP_BR, OP_CALL: taken_c = 1'b1;
      OP_BZ:          taken_c = flags_q[FLAG_ZERO];
      OP_BNZ:         taken_c = !flags_q[FLAG_ZERO];
      OP_BMI:         taken_c = flags_q[FLAG_SIGN];
      OP_BPL:         taken_c = !flags_q[FLAG_SIGN];
      OP_BCY:         taken_c = flags_q[FLAG_CARRY];
      default:        taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/minirisc_control_fsm.sv
// Multi-cycle control sequencer and PC owner for the miniRISC datapath.
// Optional performance counters are enabled with MINIRISC_PERF_CNT_EN.
module minirisc_control_fsm
  import minirisc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     MEM_WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FLAGS_W-1:0] flags,
  input  logic [PC_W-1:0]    address,
  input  logic [PC_W-1:0]    alu_result,
  output logic [PC_W-1:0]    PCin,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               DataPCSel,
  output logic               RegSelect,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [SEL_W-1:0]   ALUinSel,
  output logic               busy,
  output logic               halted,
  output logic               illegal
`ifdef MINIRISC_PERF_CNT_EN
  ,
  output logic [31:0]        instr_retired,
  output logic [31:0]        cycle_count
`endif
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, halted_q;
  ctrl_t              ctrl_q, ctrl_d;
  logic               taken_c;

  // Flags are captured in EXEC; branches resolve on that same edge from the D side.
  assign flags_d = (state_q == S_EXEC) ? flags : flags_q;
  assign pc_inc  = pc_q + PC_W'(1);

  minirisc_branch_resolve u_branch (
    .op_q    (op_q),
    .flags_q (flags_d),
    .taken_c (taken_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      flags_q   <= '0;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q  <= (state_d == S_HALT);
      ctrl_q    <= ctrl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    ctrl_d    = '0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (op_defined(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LD, OP_ST: begin
            state_d = S_MEM;
            cnt_d   = CNT_W'(MEM_WAIT_CYCLES - 1);
          end
          OP_ALU_R, OP_ALU_I, OP_CALL: state_d = S_WB;
          OP_JR: begin
            pc_d    = alu_result;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            pc_d    = pc_inc;
            state_d = S_HALT;
          end
          default: begin
            pc_d    = taken_c ? address : pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (cnt_q == '0) begin
          if (op_q == OP_LD) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        pc_d    = (op_q == OP_CALL) ? address : pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are derived from the state being entered.
    if ((state_d == S_EXEC) || (state_d == S_MEM)) begin
      case (op_d)
        OP_ALU_R: begin
          ctrl_d.alu_op     = ALUOP_RTYPE;
          ctrl_d.alu_in_sel = SEL_DATA2;
        end
        OP_ALU_I: begin
          ctrl_d.alu_op     = ALUOP_IMM;
          ctrl_d.alu_in_sel = SEL_ADDR;
        end
        OP_LD, OP_ST: begin
          ctrl_d.alu_op     = ALUOP_ADD;
          ctrl_d.alu_in_sel = SEL_ADDR;
        end
        OP_BZ, OP_BNZ, OP_BMI, OP_BPL, OP_BCY: begin
          ctrl_d.alu_op     = ALUOP_SUB;
          ctrl_d.alu_in_sel = SEL_DATA2;
        end
        OP_JR: begin
          ctrl_d.alu_op     = ALUOP_ADD;
          ctrl_d.alu_in_sel = SEL_ZERO;
        end
        default: begin
          ctrl_d.alu_op     = ALUOP_RTYPE;
          ctrl_d.alu_in_sel = SEL_DATA2;
        end
      endcase
    end
    if (state_d == S_MEM) begin
      ctrl_d.mem_read  = (op_d == OP_LD);
      ctrl_d.mem_write = (op_d == OP_ST);
    end
    if (state_d == S_WB) begin
      ctrl_d.reg_write   = 1'b1;
      ctrl_d.mem_to_reg  = (op_d == OP_ALU_R) || (op_d == OP_ALU_I);
      ctrl_d.data_pc_sel = (op_d == OP_CALL);
      ctrl_d.reg_select  = (op_d == OP_CALL);
    end
  end

  assign PCin      = pc_q;
  assign RegWrite  = ctrl_q.reg_write;
  assign MemRead   = ctrl_q.mem_read;
  assign MemWrite  = ctrl_q.mem_write;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign DataPCSel = ctrl_q.data_pc_sel;
  assign RegSelect = ctrl_q.reg_select;
  assign ALUop     = ctrl_q.alu_op;
  assign ALUinSel  = ctrl_q.alu_in_sel;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

`ifdef MINIRISC_PERF_CNT_EN
  logic        pc_upd_c, clr_perf_c;
  logic [31:0] retired_q, cycles_q;

  // An instruction retires on the edge that leaves EXEC/MEM/WB for FETCH or HALT.
  assign pc_upd_c   = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                      ((state_d == S_FETCH) || (state_d == S_HALT));
  assign clr_perf_c = start && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else if (clr_perf_c) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (pc_upd_c && (retired_q != 32'hFFFF_FFFF)) retired_q <= retired_q + 32'd1;
      if (busy_q && (cycles_q != 32'hFFFF_FFFF)) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign instr_retired = retired_q;
  assign cycle_count   = cycles_q;
`endif

endmodule

// File: tb/tb_minirisc_control_fsm.sv
// Directed plus randomized instruction stream against a per-instruction cycle model.
module tb_minirisc_control_fsm;

  localparam int unsigned MEM_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [2:0]  flags = '0;
  logic [31:0] address = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] PCin;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect;
  logic [2:0]  ALUop;
  logic [1:0]  ALUinSel;
  logic        busy, halted, illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_m = '0;
  logic        ill_m = 1'b0;

  minirisc_control_fsm #(.RESET_PC(32'h0), .MEM_WAIT_CYCLES(MEM_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .flags(flags),
    .address(address), .alu_result(alu_result), .PCin(PCin),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .DataPCSel(DataPCSel), .RegSelect(RegSelect), .ALUop(ALUop), .ALUinSel(ALUinSel),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
            ALUop, ALUinSel, busy, halted, illegal};
  endfunction

  function automatic logic [13:0] ev(input logic rw, mr, mw, m2r, dps, rs,
                                     input logic [2:0] aop, input logic [1:0] sel,
                                     input logic b, h, il);
    return {rw, mr, mw, m2r, dps, rs, aop, sel, b, h, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [13:0] e);
    check(tag, 32'(obs()), 32'(e));
    check({tag, "_pc"}, PCin, pc_m);
  endtask

  task automatic step(input bit noise);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ill_m = 1'b0;
  endtask

  // Expects the DUT in FETCH at a falling edge; leaves it in FETCH or HALT.
  task automatic run_instr(input logic [5:0] op, input logic [31:0] addr, ar,
                           input logic [2:0] fl, input bit noise);
    logic [2:0]  aop;
    logic [1:0]  sel;
    logic        tk;
    logic [31:0] npc;
    opcode = op; address = addr; alu_result = ar; flags = fl;
    chk_cycle("fetch", ev(0,0,0,0,0,0,3'd0,2'd0,1,0,0));
    step(noise);
    chk_cycle("decode", ev(0,0,0,0,0,0,3'd0,2'd0,1,0,0));
    step(noise);
    if (!((op <= 6'h0B) || (op == 6'h3F))) begin
      ill_m = 1'b1;
      chk_cycle("illegal_halt", ev(0,0,0,0,0,0,3'd0,2'd0,0,1,1));
      start = 1'b0;
      return;
    end
    case (op)
      6'h01:                      begin aop = 3'd3; sel = 2'd2; end
      6'h02, 6'h03:               begin aop = 3'd1; sel = 2'd2; end
      6'h05, 6'h06, 6'h07, 6'h08, 6'h09: begin aop = 3'd2; sel = 2'd0; end
      6'h0B:                      begin aop = 3'd1; sel = 2'd1; end
      default:                    begin aop = 3'd0; sel = 2'd0; end
    endcase
    chk_cycle("exec", ev(0,0,0,0,0,0,aop,sel,1,0,0));
    if (op == 6'h02 || op == 6'h03) begin
      for (int i = 0; i < int'(MEM_W); i++) begin
        step(noise);
        chk_cycle("mem", ev(0, op == 6'h02, op == 6'h03, 0,0,0, aop, sel, 1,0,0));
      end
    end
    if (op <= 6'h02 || op == 6'h0A) begin
      step(noise);
      chk_cycle("wb", ev(1,0,0, op <= 6'h01, op == 6'h0A, op == 6'h0A, 3'd0,2'd0,1,0,0));
    end
    case (op)
      6'h04, 6'h0A: tk = 1'b1;
      6'h05:        tk = fl[0];
      6'h06:        tk = !fl[0];
      6'h07:        tk = fl[1];
      6'h08:        tk = !fl[1];
      6'h09:        tk = fl[2];
      default:      tk = 1'b0;
    endcase
    npc = (op == 6'h0B) ? ar : (tk ? addr : pc_m + 32'd1);
    step(noise);
    start = 1'b0;
    pc_m = npc;
    if (op == 6'h3F)
      chk_cycle("halt_op", ev(0,0,0,0,0,0,3'd0,2'd0,0,1,0));
  endtask

  initial begin
    logic [5:0] rop;
    int r;
    #1 reset = 1'b0;
    #2;
    chk_cycle("reset", 14'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cycle("idle", 14'd0);
    @(negedge clk);
    chk_cycle("idle_hold", 14'd0);
    do_start();

    run_instr(6'h00, 32'h0000_0500, 32'h0, 3'b000, 0);
    check("alu_r_pc", PCin, 32'h1);
    run_instr(6'h02, 32'h0000_0100, 32'h0, 3'b000, 0);
    run_instr(6'h03, 32'h0000_0104, 32'h0, 3'b000, 0);
    run_instr(6'h05, 32'h0000_0040, 32'h0, 3'b001, 0);
    check("bz_taken_pc", PCin, 32'h40);
    run_instr(6'h05, 32'h0000_0080, 32'h0, 3'b000, 0);
    check("bz_not_taken_pc", PCin, 32'h41);
    run_instr(6'h09, 32'h0000_0020, 32'h0, 3'b100, 0);
    check("bcy_taken_pc", PCin, 32'h20);
    run_instr(6'h04, 32'h0000_0010, 32'h0, 3'b000, 0);
    run_instr(6'h0A, 32'h0000_0080, 32'h0, 3'b000, 0);
    check("call_pc", PCin, 32'h80);
    run_instr(6'h0B, 32'h0000_0033, 32'h11, 3'b000, 0);
    check("jr_pc", PCin, 32'h11);
    run_instr(6'h2A, 32'h0000_0099, 32'h0, 3'b000, 0);
    check("illegal_pc_hold", PCin, 32'h11);
    do_start();
    run_instr(6'h01, 32'h0000_0007, 32'h0, 3'b000, 0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 15);
      if (r <= 11)      rop = 6'(r);
      else if (r == 12) rop = 6'($urandom_range(12, 62));
      else              rop = 6'h00;
      run_instr(rop, $urandom, $urandom, 3'($urandom_range(0, 7)), 1);
      if (halted) do_start();
    end

    run_instr(6'h04, 32'h0000_1234, 32'h0, 3'b000, 0);
    opcode = 6'h02;
    step(0);
    step(0);
    chk_cycle("pre_reset_exec", ev(0,0,0,0,0,0,3'd1,2'd2,1,0,0));
    #2 reset = 1'b0;
    pc_m = 32'h0;
    ill_m = 1'b0;
    #1;
    chk_cycle("async_reset", 14'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cycle("idle_after_reset", 14'd0);
    do_start();

    run_instr(6'h04, 32'hFFFF_FFFF, 32'h0, 3'b000, 0);
    run_instr(6'h3F, 32'h0000_0000, 32'h0, 3'b000, 0);
    check("halt_wrap_pc", PCin, 32'h0);
    @(negedge clk);
    chk_cycle("halt_hold", ev(0,0,0,0,0,0,3'd0,2'd0,0,1,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/minirisc_control_fsm.md
Name: minirisc_control_fsm

Overview:
Multi-cycle sequencer for the KGP-miniRISC arithmetic-and-memory datapath. It owns the program counter and drives the datapath control strobes: RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop and ALUinSel. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, then resolves branches from the ALU flags. It sits between the top-level start/halt interface and the datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WAIT_CYCLES, 1, cycles spent in MEM per load/store (legal 1..4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins or resumes execution from IDLE/HALT
opcode  input  6  instruction[31:26] from datapath
flags  input  3  ALU flags: [0]=zero, [1]=sign, [2]=carry
address  input  32  zero-extended immediate from datapath (absolute branch/call target)
alu_result  input  32  ALU result (jump-register target)
PCin  output  32  current PC to instruction memory/datapath
RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect  output  1 each  datapath strobes
ALUop  output  3  ALU control class
ALUinSel  output  2  ALU B-input select: 0=data2, 1=zero, 2=address, 3=one
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
illegal  output  1  sticky; set on an undefined opcode, cleared by start or reset

Behaviour:
- Reset (async, reset=0): state=IDLE, PCin=RESET_PC, all strobes, ALUop, ALUinSel, busy, halted and illegal = 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE/HALT: start -> FETCH and clear illegal. Otherwise hold. PC is not changed.
- FETCH: 1 cycle, PCin stable. DECODE: latch opcode into op_q, 1 cycle. Strobes low in both.
- Opcode classes: ALU_R=0x00, ALU_I=0x01, LD=0x02, ST=0x03, BR=0x04, BZ=0x05, BNZ=0x06, BMI=0x07, BPL=0x08, BCY=0x09, CALL=0x0A, JR=0x0B, HALT=0x3F. Any other opcode is undefined: DECODE -> HALT with illegal=1.
- EXEC (1 cycle), ALUop/ALUinSel per class:
  - ALU_R: RTYPE / data2.
  - ALU_I: IMM / address.
  - LD/ST: ADD / address.
  - BZ..BCY: SUB / data2.
  - JR: ADD / zero.
  - BR/CALL: no ALU use.
  - flags are registered at the end of EXEC.
- MEM (LD/ST only): ALUop/ALUinSel held. MemRead (LD) or MemWrite (ST) is high for exactly MEM_WAIT_CYCLES cycles, counted by a down-counter. ST then goes to the PC-update step; LD goes to WB.
- WB: RegWrite high for exactly one cycle.
  - ALU_R/ALU_I: MemtoReg=1, selects ALU result.
  - LD: MemtoReg=0.
  - CALL: DataPCSel=1, RegSelect=1, so PC+1 is written to r31.
- PC update on the final edge of each instruction, then -> FETCH:
  - default: PC+1, 32-bit wrap (0xFFFF_FFFF -> 0).
  - BR/CALL: address.
  - JR: alu_result, sampled in EXEC.
  - BZ: zero=1. BNZ: zero=0. BMI: sign=1. BPL: sign=0. BCY: carry=1. Taken -> address, else PC+1.
  - HALT opcode: PC+1, then -> HALT.
- Final state per class: ALU_R/ALU_I/LD/CALL end in WB. ST ends in MEM. Branches and JR end in EXEC.
- start outside IDLE/HALT is ignored. Reset mid-instruction aborts with no partial write beyond edges already taken.
- ALUop encodings: RTYPE=0, ADD=1, SUB=2, IMM=3.

Optional Feature:
- Macro MINIRISC_PERF_CNT_EN. When defined, adds output ports instr_retired[31:0] and cycle_count[31:0].
  - instr_retired increments on each PC-update edge.
  - cycle_count increments every cycle while busy.
  - Both saturate at 0xFFFF_FFFF, reset to 0 and clear on start from IDLE, but not from HALT.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package minirisc_ctrl_pkg holds the state enum, opcode class constants, ALUop constants, ALUinSel constants and flag bit indices.
- One sub-module, minirisc_branch_resolve: combinational; takes op_q and flags_q, returns taken.

Test Plan:
- Reset asserted mid-EXEC -> PCin=0, all strobes 0, busy=0 immediately, with no clock edge needed.
- start; ALU_R at PC 0 -> FETCH, DECODE, EXEC, WB = 4 cycles; RegWrite=1 with MemtoReg=1 only in cycle 4; PCin=1 after.
- LD with MEM_WAIT_CYCLES=3 -> MemRead high exactly 3 cycles, RegWrite=1 and MemtoReg=0 for 1 cycle; ST -> MemWrite 3 cycles, RegWrite never asserted.
- BZ, address=0x40: flags=3'b001 -> PCin=0x40. flags=3'b000 -> PCin=PC+1. BCY with flags=3'b100 -> taken.
- CALL at PC 0x10, address=0x80 -> WB has DataPCSel=1, RegSelect=1, RegWrite=1; next PCin=0x80. JR with alu_result=0x11 -> PCin=0x11.
- Opcode 0x2A -> HALT with illegal=1, busy=0, PC unchanged. Then start -> illegal=0, FETCH from same PC. HALT opcode at 0xFFFF_FFFF -> PCin wraps to 0, halted=1.
